pito_uart_tx_periph: RTL and testbench
======================================

Name: pito_uart_tx_periph

Overview:
- Memory-mapped UART transmitter that acts as a responder on the pito data-memory bus.
- The core drives dmem_req/we/addr/be/wdata; this block decodes its address window, buffers bytes in a FIFO, serialises them 8N1 onto uart_tx, returns register reads on dmem_rdata, and raises uart_irq toward the core's io modport.
- Its dmem_rdata is zero when not selected, so it is OR-ed with the RAM read data at SoC level.

Parameters:
- DMEM_AW, 12: width of dmem_addr (word address).
- BASE_ADDR, 12'hFF0: base word address of the register window. Low 2 bits are ignored.
- FIFO_DEPTH, 8: TX FIFO entries. Power of 2, minimum 2.
- CLKS_PER_BIT, 434: reset value of the baud divisor (clocks per serial bit).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dmem_req  in  1  bus request, single-cycle per access
- dmem_we  in  1  1 = write, 0 = read
- dmem_addr  in  DMEM_AW  word address
- dmem_be  in  4  byte enables for writes
- dmem_wdata  in  32  write data
- dmem_rdata  out  32  read data, registered, 1-cycle latency
- uart_tx  out  1  serial output, idle high
- uart_irq  out  1  level interrupt

Behaviour:
- Reset is asynchronous and active-low: rst_n low clears all state immediately; the block is synchronous to clk otherwise. Clock is clk, reset is rst_n.
- Reset values: dmem_rdata=0, uart_tx=1, uart_irq=0, FIFO empty, FSM=IDLE, CTRL=0, DIV=CLKS_PER_BIT, OVF=0.
- sel = dmem_req && (dmem_addr[DMEM_AW-1:2] == BASE_ADDR[DMEM_AW-1:2]). Register index = dmem_addr[1:0].
- Register map (index: name):
  - 0: TXDATA. A write with be[0] pushes wdata[7:0]. Reads return 0.
  - 1: STATUS, read-only except OVF. bit0 busy (FSM≠IDLE), bit1 full, bit2 empty, bit3 OVF (sticky), bits[11:8] FIFO level. Writing 1 to bit3 with be[0] clears OVF.
  - 2: CTRL. bit0 irq_en. Written when be[0].
  - 3: DIV. bits[15:0] divisor, honouring be[1:0]. Stored as written; an effective value of 0 is treated as 1.
- Reads: dmem_rdata is updated in the cycle after a selected read. Unselected or write cycles load 0 the next cycle. No wait states; every request is accepted.
- Push to a full FIFO is dropped and sets OVF, unless a pop occurs in the same cycle; in that case the push is accepted and the level is unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop, latch the byte and the effective divisor, go to START.
  - START: uart_tx=0 for DIV clocks.
  - DATA: 8 bits, LSB first, DIV clocks each.
  - STOP: uart_tx=1 for DIV clocks. At the end, if the FIFO is not empty, pop and go directly to START; else go to IDLE.
  - uart_tx is registered. The start bit begins the cycle after the pop.
  - One frame is exactly 10*DIV clocks; back-to-back frames have no idle gap.
- A DIV write mid-frame takes effect at the next frame's pop only.
- uart_irq = irq_en && FIFO empty && FSM==IDLE, registered (one cycle after the condition).
- Reset asserted mid-frame: uart_tx returns to 1 immediately and the frame is abandoned.

Test Plan:
- Reset then read STATUS at BASE_ADDR+1 -> dmem_rdata=0x0000_0004 one cycle after request; uart_tx=1; uart_irq=0.
- DIV=4, write 0xA5 to TXDATA -> starting the cycle after the pop, uart_tx holds each bit for 4 clocks: 0,1,0,1,0,0,1,0,1,1. Frame length 40 clocks. STATUS.busy=1 during the frame.
- DIV=2, 9 back-to-back TXDATA writes while the line is idle -> the first byte is popped immediately and 8 fill the FIFO, so none is dropped. A 10th write while full with no pop -> OVF=1. Writing 0x8 to STATUS -> OVF=0. Total 9 frames in 180 clocks, no idle gap.
- CTRL=1, send one byte with DIV=3 -> uart_irq=0 during the frame and rises 1 cycle after the FSM returns to IDLE. Clearing irq_en -> uart_irq=0 next cycle.
- Write DIV=0, send 0xFF -> each bit lasts 1 clock (10-clock frame). A DIV write of 8 mid-frame does not change the current frame.
- Read of an address outside the window, and a write to TXDATA with be=4'b1110 -> dmem_rdata=0 and no push; FIFO level stays 0.

Source files
------------

// File: rtl/pito_uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the pito dmem bus; reads return registered data one cycle after the request.
// Never stalls the bus: TXDATA writes into a full FIFO are dropped and flagged in STATUS.OVF instead of backpressured.
module pito_uart_tx_periph #(
    parameter int                 DMEM_AW      = 12,
    parameter logic [DMEM_AW-1:0] BASE_ADDR    = 12'hFF0,
    parameter int                 FIFO_DEPTH   = 8,
    parameter int                 CLKS_PER_BIT = 434
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dmem_req,
    input  logic               dmem_we,
    input  logic [DMEM_AW-1:0] dmem_addr,
    input  logic [3:0]         dmem_be,
    input  logic [31:0]        dmem_wdata,
    output logic [31:0]        dmem_rdata,
    output logic               uart_tx,
    output logic               uart_irq
);
    localparam int             PW       = $clog2(FIFO_DEPTH);
    localparam int             CW       = PW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]    DIV_RST  = 16'(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           ovf, irq_en;
    logic [15:0]    div, div_lat, clk_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;

    logic           sel, wr, rd, push_req, push, pop, full, empty, bit_end;
    logic [1:0]     idx;
    logic [15:0]    div_eff;
    logic [31:0]    rd_val;

    assign sel      = dmem_req && (dmem_addr[DMEM_AW-1:2] == BASE_ADDR[DMEM_AW-1:2]);
    assign idx      = dmem_addr[1:0];
    assign wr       = sel && dmem_we;
    assign rd       = sel && !dmem_we;
    assign push_req = wr && (idx == 2'd0) && dmem_be[0];
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign bit_end  = (clk_cnt == div_lat - 16'd1);
    assign div_eff  = (div == 16'd0) ? 16'd1 : div;
    // A pop at the end of a stop bit frees a slot, so a simultaneous push into a full FIFO still fits.
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign push     = push_req && (!full || pop);

    always_comb begin
        rd_val = '0;
        if (rd) begin
            case (idx)
                2'd1:    rd_val = {20'd0, 4'(count), 4'd0, ovf, empty, full, (state != IDLE)};
                2'd2:    rd_val = {31'd0, irq_en};
                2'd3:    rd_val = {16'd0, div};
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= dmem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf        <= 1'b0;
            irq_en     <= 1'b0;
            div        <= DIV_RST;
            dmem_rdata <= '0;
            uart_irq   <= 1'b0;
        end else begin
            dmem_rdata <= rd_val;
            uart_irq   <= irq_en && empty && (state == IDLE);
            if (push_req && full && !pop)
                ovf <= 1'b1;
            else if (wr && (idx == 2'd1) && dmem_be[0] && dmem_wdata[3])
                ovf <= 1'b0;
            if (wr && (idx == 2'd2) && dmem_be[0])
                irq_en <= dmem_wdata[0];
            if (wr && (idx == 2'd3)) begin
                if (dmem_be[0]) div[7:0]  <= dmem_wdata[7:0];
                if (dmem_be[1]) div[15:8] <= dmem_wdata[15:8];
            end
        end
    end

    // The divisor is latched per frame so a DIV write only affects frames popped after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            uart_tx <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            div_lat <= 16'd1;
        end else if (pop) begin
            shreg   <= mem[rd_ptr];
            div_lat <= div_eff;
            clk_cnt <= '0;
            state   <= START;
            uart_tx <= 1'b0;
        end else begin
            case (state)
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        uart_tx <= shreg[0];
                        shreg   <= shreg >> 1;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            uart_tx <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        uart_tx <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: begin
                    clk_cnt <= '0;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pito_uart_tx_periph.sv
// Bench for pito_uart_tx_periph: register access plus line waveforms compared against a frame-level model
// (each frame = start 0, 8 data bits LSB first, stop 1, every bit lasting the effective divisor).
module tb_pito_uart_tx_periph;
    localparam logic [11:0] BASE   = 12'hFF0;
    localparam logic [11:0] A_TX   = BASE;
    localparam logic [11:0] A_STAT = BASE + 12'd1;
    localparam logic [11:0] A_CTRL = BASE + 12'd2;
    localparam logic [11:0] A_DIV  = BASE + 12'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_we = 1'b0;
    logic [11:0] dmem_addr = '0;
    logic [3:0]  dmem_be = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        uart_tx;
    logic        uart_irq;

    int errors = 0;
    int checks = 0;

    logic       cap_tx  [0:511];
    logic       cap_irq [0:511];
    logic [7:0] exp_b   [0:15];
    int         exp_d   [0:15];
    int         exp_n = 0;

    pito_uart_tx_periph #(
        .DMEM_AW(12), .BASE_ADDR(12'hFF0), .FIFO_DEPTH(8), .CLKS_PER_BIT(434)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .uart_tx(uart_tx), .uart_irq(uart_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // All bus tasks are entered on a negedge and return on the following negedge.
    task automatic bus_write(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = a; dmem_be = be; dmem_wdata = d;
        @(negedge clk);
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_be = '0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = a; dmem_be = '0;
        @(negedge clk);
        dmem_req = 1'b0;
        d = dmem_rdata;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_tx[i]  = uart_tx;
            cap_irq[i] = uart_irq;
            @(negedge clk);
        end
    endtask

    task automatic add_frame(input logic [7:0] b, input int d);
        exp_b[exp_n] = b;
        exp_d[exp_n] = (d == 0) ? 1 : d;
        exp_n++;
    endtask

    // Sample k counts negedges from the one where the first TXDATA write is driven;
    // the line stays idle for that sample and the next, then frames follow back to back.
    function automatic logic exp_line(input int k);
        int t;
        t = k - 2;
        if (t < 0) return 1'b1;
        for (int f = 0; f < exp_n; f++) begin
            if (t < 10 * exp_d[f]) begin
                int b;
                b = t / exp_d[f];
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return exp_b[f][b-1];
            end
            t -= 10 * exp_d[f];
        end
        return 1'b1;
    endfunction

    function automatic int wave_mm(input int n, output int first);
        int mm;
        mm = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            if (cap_tx[i] !== exp_line(i)) begin
                if (first < 0) first = i;
                mm++;
            end
        end
        return mm;
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        checks++; if (uart_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", uart_irq); end
        checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", dmem_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(A_STAT, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status: got %h want 00000004", d); end
        bus_read(A_CTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", d); end
        bus_read(A_DIV, d);
        checks++; if (d !== 32'd434) begin errors++; $display("FAIL reset_div: got %0d want 434", d); end
    endtask

    task automatic test_single_frame;
        logic [31:0] d;
        int mm, first;
        bus_write(A_DIV, 4'b0011, 32'd4);
        exp_n = 0;
        add_frame(8'hA5, 4);
        fork
            capture(46);
            begin
                bus_write(A_TX, 4'b0001, 32'hA5);
                repeat (9) @(negedge clk);
                bus_read(A_STAT, d);
                checks++; if (d !== 32'h5) begin errors++; $display("FAIL frame_busy_status: got %h want 00000005", d); end
            end
        join
        mm = wave_mm(46, first);
        checks++; if (mm !== 0) begin errors++; $display("FAIL frame_a5_wave: %0d bad samples, first at %0d", mm, first); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        int mm, first;
        bus_write(A_DIV, 4'b0011, 32'd2);
        exp_n = 0;
        for (int i = 0; i < 9; i++) add_frame(8'($urandom_range(255, 0)), 2);
        fork
            capture(186);
            begin
                for (int i = 0; i < 9; i++) bus_write(A_TX, 4'b0001, {24'd0, exp_b[i]});
                bus_write(A_TX, 4'b0001, 32'($urandom_range(255, 0)));
                bus_read(A_STAT, d);
                checks++; if (d !== 32'h80B) begin errors++; $display("FAIL b2b_ovf_status: got %h want 0000080b", d); end
                bus_write(A_STAT, 4'b0001, 32'h8);
                bus_read(A_STAT, d);
                checks++; if (d !== 32'h803) begin errors++; $display("FAIL b2b_ovf_clear: got %h want 00000803", d); end
            end
        join
        mm = wave_mm(186, first);
        checks++; if (mm !== 0) begin errors++; $display("FAIL b2b_wave: %0d bad samples, first at %0d", mm, first); end
        bus_read(A_STAT, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL b2b_drained: got %h want 00000004", d); end
    endtask

    task automatic test_irq;
        int mm, first, bad_irq;
        logic [7:0] b;
        bus_write(A_DIV, 4'b0011, 32'd3);
        bus_write(A_CTRL, 4'b0001, 32'h1);
        checks++; if (uart_irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b want 0", uart_irq); end
        @(negedge clk);
        checks++; if (uart_irq !== 1'b1) begin errors++; $display("FAIL irq_idle: got %b want 1", uart_irq); end
        b = 8'($urandom_range(255, 0));
        exp_n = 0;
        add_frame(b, 3);
        fork
            capture(36);
            bus_write(A_TX, 4'b0001, {24'd0, b});
        join
        mm = wave_mm(36, first);
        checks++; if (mm !== 0) begin errors++; $display("FAIL irq_frame_wave: %0d bad samples, first at %0d", mm, first); end
        bad_irq = 0;
        for (int i = 2; i <= 32; i++) if (cap_irq[i] !== 1'b0) bad_irq++;
        checks++; if (bad_irq !== 0) begin errors++; $display("FAIL irq_during_frame: %0d samples high, want 0", bad_irq); end
        checks++; if (cap_irq[33] !== 1'b1) begin errors++; $display("FAIL irq_after_frame: got %b want 1", cap_irq[33]); end
        bus_write(A_CTRL, 4'b0001, 32'h0);
        @(negedge clk);
        checks++; if (uart_irq !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b want 0", uart_irq); end
    endtask

    task automatic test_div_zero;
        logic [31:0] d;
        logic [7:0] b;
        int mm, first;
        bus_write(A_DIV, 4'b0011, 32'd0);
        bus_read(A_DIV, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL div0_stored: got %h want 0", d); end
        b = 8'($urandom_range(255, 0));
        exp_n = 0;
        add_frame(8'hFF, 0);
        add_frame(b, 8);
        fork
            capture(96);
            begin
                bus_write(A_TX, 4'b0001, 32'hFF);
                @(negedge clk);
                bus_write(A_DIV, 4'b0011, 32'd8);
                bus_write(A_TX, 4'b0001, {24'd0, b});
            end
        join
        mm = wave_mm(96, first);
        checks++; if (mm !== 0) begin errors++; $display("FAIL div0_then_div8_wave: %0d bad samples, first at %0d", mm, first); end
    endtask

    task automatic test_misc;
        logic [31:0] d;
        int hi;
        bus_read(A_STAT, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL misc_status: got %h want 00000004", d); end
        bus_read(BASE - 12'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL misc_below_window: got %h want 0", d); end
        bus_read(BASE + 12'd4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL misc_above_window: got %h want 0", d); end
        bus_read(A_TX, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL misc_txdata_read: got %h want 0", d); end
        bus_write(A_TX, 4'b1110, 32'hFFFF_FFFF);
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (uart_tx !== 1'b1) hi++;
            @(negedge clk);
        end
        checks++; if (hi !== 0) begin errors++; $display("FAIL misc_no_push_line: %0d low samples, want 0", hi); end
        bus_read(A_STAT, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL misc_no_push_level: got %h want 00000004", d); end
        bus_write(A_DIV, 4'b0010, 32'h1234_5678);
        bus_read(A_DIV, d);
        checks++; if (d !== 32'h5608) begin errors++; $display("FAIL misc_div_be: got %h want 00005608", d); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        bus_write(A_DIV, 4'b0011, 32'd4);
        bus_write(A_TX, 4'b0001, 32'($urandom_range(255, 0)));
        @(negedge clk);
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midrst_start_bit: got %b want 0", uart_tx); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midrst_tx_async: got %b want 1", uart_tx); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(A_STAT, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL midrst_status: got %h want 00000004", d); end
        bus_read(A_DIV, d);
        checks++; if (d !== 32'd434) begin errors++; $display("FAIL midrst_div: got %0d want 434", d); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midrst_line_idle: got %b want 1", uart_tx); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_irq();
        test_div_zero();
        test_misc();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
